// File: rtl/step_motor_sequencer_if.sv
// step_motor_sequencer_if
//   Move-command handshake between a command source and the step motor
//   sequencer. The command is taken on a clock edge where cmd_valid and
//   cmd_ready are both high.
//   Signals:
//     cmd_valid  - command present (source -> sequencer)
//     cmd_ready  - sequencer idle and able to accept (sequencer -> source)
//     cmd_dir    - 1 = forward (phase +1), 0 = reverse (phase -1)
//     cmd_steps  - half-steps to move (CNT_W bits)
//     cmd_period - clocks per half-step, 0 treated as 1 (PER_W bits)
//   Modports: master = command source, slave = sequencer.
interface step_motor_sequencer_if #(
  parameter int PER_W = 16,
  parameter int CNT_W = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/step_motor_sequencer.sv
// step_motor_sequencer
//   Half-step sequencer for a 4-coil stepper. A move command energizes the
//   coils with the pattern for the current phase, then advances the phase
//   once every Peff clocks until the requested number of half-steps has
//   been issued or the move is aborted. The last pattern is held after the
//   move so the motor keeps holding torque.
//   Ports:
//     clk        - clock, all state changes on the rising edge
//     reset      - synchronous active-low reset
//     cmd        - move command handshake (slave side)
//     abort      - end the move in progress (only acted on while running)
//     step_motor - registered coil drive pattern
//     position   - current phase index 0..7
//     steps_left - half-steps remaining in the current move
//     busy       - high whenever the sequencer is not idle
//     done       - one-cycle pulse when a move ends
module step_motor_sequencer #(
  parameter int PER_W = 16,
  parameter int CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  step_motor_sequencer_if.slave cmd,
  input  logic                 abort,
  output logic [3:0]           step_motor,
  output logic [2:0]           position,
  output logic [CNT_W-1:0]     steps_left,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             dir;
  logic [PER_W-1:0] per;   // effective period, never 0
  logic [PER_W-1:0] cnt;
  logic             ready_q;
  logic [2:0]       pos_nxt;

  assign cmd.cmd_ready = ready_q;

  // 3-bit phase arithmetic wraps 7<->0 on its own.
  assign pos_nxt = dir ? position + 3'd1 : position - 3'd1;

  function automatic logic [3:0] pattern(input logic [2:0] p);
    case (p)
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b1100;
      3'd2:    pattern = 4'b0100;
      3'd3:    pattern = 4'b0110;
      3'd4:    pattern = 4'b0010;
      3'd5:    pattern = 4'b0011;
      3'd6:    pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      step_motor <= 4'b0000;
      position   <= 3'd0;
      steps_left <= '0;
      cnt        <= '0;
      per        <= PER_W'(1);
      dir        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            dir        <= cmd.cmd_dir;
            per        <= (cmd.cmd_period == '0) ? PER_W'(1) : cmd.cmd_period;
            // Coils are energized at acceptance even for a zero-step move.
            step_motor <= pattern(position);
            cnt        <= '0;
            busy       <= 1'b1;
            ready_q    <= 1'b0;
            if (cmd.cmd_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= RUN;
              steps_left <= cmd.cmd_steps;
            end
          end
        end
        RUN: begin
          // Abort wins over a step that is due on the same edge.
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (cnt == per - PER_W'(1)) begin
            position   <= pos_nxt;
            step_motor <= pattern(pos_nxt);
            steps_left <= steps_left - CNT_W'(1);
            cnt        <= '0;
            if (steps_left == CNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + PER_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// tb_step_motor_sequencer
//   Directed bench for step_motor_sequencer. Each move pushes its expected
//   coil patterns / phase / remaining count, tagged with the cycle after
//   acceptance where they must appear, onto a queue; the per-cycle monitor
//   pops entries as their cycle comes up and compares every cycle.
module tb_step_motor_sequencer;
  localparam int PER_W = 16;
  localparam int CNT_W = 10;

  typedef struct {
    int               cyc;
    logic [3:0]       pat;
    logic [2:0]       pos;
    logic [CNT_W-1:0] sl;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             abort = 1'b0;
  logic [3:0]       step_motor;
  logic [2:0]       position;
  logic [CNT_W-1:0] steps_left;
  logic             busy;
  logic             done;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [2:0] pos_m = 3'd0;

  step_motor_sequencer_if #(.PER_W(PER_W), .CNT_W(CNT_W)) cmd_if ();

  step_motor_sequencer #(.PER_W(PER_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .abort      (abort),
    .step_motor (step_motor),
    .position   (position),
    .steps_left (steps_left),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input logic [2:0] p);
    logic [3:0] tbl [8];
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
            4'b0010, 4'b0011, 4'b0001, 4'b1001};
    return tbl[p];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " step_motor"}, 32'(step_motor), 32'h0);
    chk({tag, " position"},   32'(position),   32'h0);
    chk({tag, " steps_left"}, 32'(steps_left), 32'h0);
    chk({tag, " busy"},       32'(busy),       32'h0);
    chk({tag, " done"},       32'(done),       32'h0);
    chk({tag, " cmd_ready"},  32'(cmd_if.cmd_ready), 32'h1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b1;
    pos_m = 3'd0;
  endtask

  // abort_at: cycle after acceptance whose edge sees abort=1 (0 = none).
  // hold: keep cmd_valid high with different fields while the move runs.
  task automatic run_move(input string tag, input logic d, input int steps,
                          input int per, input int abort_at, input bit hold);
    int   peff;
    int   done_at;
    exp_t e;
    exp_t cur;
    peff = (per == 0) ? 1 : per;
    q.delete();
    e.cyc = 0; e.pat = pat(pos_m); e.pos = pos_m; e.sl = CNT_W'(steps);
    q.push_back(e);
    done_at = 0;
    for (int k = 1; k <= steps; k++) begin
      if (abort_at > 0 && k * peff >= abort_at) begin
        done_at = abort_at;
        break;
      end
      pos_m = d ? pos_m + 3'd1 : pos_m - 3'd1;
      e.cyc = k * peff; e.pat = pat(pos_m); e.pos = pos_m; e.sl = CNT_W'(steps - k);
      q.push_back(e);
      done_at = k * peff;
    end

    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = d;
    cmd_if.cmd_steps  = CNT_W'(steps);
    cmd_if.cmd_period = PER_W'(per);

    for (int c = 0; c <= done_at + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        if (hold) begin
          cmd_if.cmd_dir    = ~d;
          cmd_if.cmd_steps  = CNT_W'(7);
          cmd_if.cmd_period = PER_W'(1);
        end else begin
          cmd_if.cmd_valid = 1'b0;
        end
      end
      if (q.size() > 0 && q[0].cyc == c) cur = q.pop_front();
      chk({tag, " step_motor"}, 32'(step_motor), 32'(cur.pat));
      chk({tag, " position"},   32'(position),   32'(cur.pos));
      if (steps > 0) chk({tag, " steps_left"}, 32'(steps_left), 32'(cur.sl));
      if (c < done_at) begin
        chk({tag, " busy"},      32'(busy), 32'h1);
        chk({tag, " done"},      32'(done), 32'h0);
        chk({tag, " cmd_ready"}, 32'(cmd_if.cmd_ready), 32'h0);
      end else if (c == done_at) begin
        chk({tag, " done pulse"}, 32'(done), 32'h1);
        chk({tag, " busy@done"},  32'(busy), 32'h1);
        cmd_if.cmd_valid = 1'b0;
      end else begin
        chk({tag, " done end"},   32'(done), 32'h0);
        chk({tag, " busy end"},   32'(busy), 32'h0);
        chk({tag, " ready end"},  32'(cmd_if.cmd_ready), 32'h1);
      end
      if (abort_at > 0 && c == abort_at - 1) abort = 1'b1;
      if (c == abort_at) abort = 1'b0;
    end
    chk({tag, " queue drained"}, 32'(q.size()), 32'h0);
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_steps  = '0;
    cmd_if.cmd_period = '0;

    do_reset(2);
    run_move("fwd", 1'b1, 3, 4, 0, 1'b0);
    chk("fwd final position", 32'(position), 32'd3);

    do_reset(2);
    run_move("rev_wrap", 1'b0, 2, 1, 0, 1'b0);
    chk("rev_wrap final position", 32'(position), 32'd6);

    do_reset(2);
    run_move("zero_per", 1'b1, 10, 0, 0, 1'b0);
    chk("zero_per final position", 32'(position), 32'd2);

    do_reset(2);
    run_move("abort", 1'b1, 5, 4, 6, 1'b0);
    chk("abort final position", 32'(position), 32'd1);
    chk("abort steps_left", 32'(steps_left), 32'd4);

    // Abort outside RUN must do nothing.
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort idle busy", 32'(busy), 32'h0);
    chk("abort idle ready", 32'(cmd_if.cmd_ready), 32'h1);

    run_move("zero_steps", 1'b1, 0, 3, 0, 1'b0);
    chk("zero_steps position", 32'(position), 32'd1);

    run_move("busy_cmd", 1'b0, 3, 2, 0, 1'b1);
    chk("busy_cmd final position", 32'(position), 32'd6);

    // Reset mid-RUN overrides valid, abort and any due step.
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = 1'b1;
    cmd_if.cmd_steps  = CNT_W'(5);
    cmd_if.cmd_period = PER_W'(2);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun busy before reset", 32'(busy), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check_idle("midrun reset");
    reset = 1'b1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check_idle("after midrun reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/step_motor_sequencer.md
STEP_MOTOR_SEQUENCER -- requirements
Module: step_motor_sequencer

Interface
REQ-001 SHALL have parameter PER_W, default 16: width of the step-period field, in clocks per step.
REQ-002 SHALL have parameter CNT_W, default 10: width of the step-count field.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: move command present.
REQ-006 SHALL have port cmd_ready, output, 1: sequencer can accept a command.
REQ-007 SHALL have port cmd_dir, input, 1: 1 = forward (phase +1), 0 = reverse (phase -1).
REQ-008 SHALL have port cmd_steps, input, CNT_W: number of half-steps to move.
REQ-009 SHALL have port cmd_period, input, PER_W: clocks per half-step.
REQ-010 SHALL have port abort, input, 1: terminate the move in progress.
REQ-011 SHALL have port step_motor, output, 4: registered coil drive pattern.
REQ-012 SHALL have port position, output, 3: current phase index.
REQ-013 SHALL have port steps_left, output, CNT_W: remaining half-steps of the current move.
REQ-014 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle move-complete pulse.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a command at edge E0 where cmd_valid=1 and the state is IDLE, and SHALL latch cmd_dir, cmd_steps and Peff, where Peff = cmd_period, or 1 when cmd_period = 0.
REQ-018 SHALL, at E0, load step_motor with pattern(position), energizing the coils even when cmd_steps = 0.
REQ-019 SHALL, at E0, go to DONE if cmd_steps = 0; otherwise it SHALL go to RUN with cnt=0 and steps_left=cmd_steps.
REQ-020 SHALL, on each RUN edge with cnt = Peff-1, step: position ±1 mod 8, step_motor from pattern(new position) at the same edge, steps_left-1, cnt=0; otherwise cnt+1.
REQ-021 SHALL place the k-th step at edge E0 + k*Peff; on the step that brings steps_left to 0, the state SHALL go to DONE.
REQ-022 SHALL use this pattern table: 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001.
REQ-023 SHALL wrap position: 7 forward goes to 0; 0 reverse goes to 7.
REQ-024 SHALL, on abort=1 at any RUN edge, go to DONE with no step that edge (abort beats a due step), keeping position and steps_left as-is.
REQ-025 SHALL ignore abort in IDLE and DONE.
REQ-026 SHALL hold done=1 for exactly the one cycle the state is DONE, then return to IDLE at the next edge.
REQ-027 SHALL ignore cmd_valid outside IDLE: no queuing and no latching.
REQ-028 SHALL hold step_motor at its last pattern after a move (holding torque) until the next step or reset.
REQ-029 SHALL treat cnt as PER_W bits and steps_left as CNT_W bits, with no overflow possible.

Reset
REQ-030 SHALL, on a clock edge with reset=0 (including mid-move), set state=IDLE, step_motor=0000, position=0, steps_left=0, cnt=0, done=0, busy=0 and cmd_ready=1.
REQ-031 SHALL let reset override cmd_valid, abort and a due step in the same cycle.

Verification
REQ-032 SHALL cover reset: hold reset=0 for 2 clocks -> step_motor=0000, position=0, busy=0, done=0, cmd_ready=1.
REQ-033 SHALL cover a forward move: dir=1, steps=3, period=4 at E0 -> step_motor 1000@E0, 1100@E0+4, 0100@E0+8, 0110@E0+12; done high the following cycle; position=3.
REQ-034 SHALL cover a reverse wrap: from position 0, dir=0, steps=2, period=1 -> 1001@E0+1, 0001@E0+2; position=6; done one cycle later.
REQ-035 SHALL cover zero period with forward wrap: from position 0, dir=1, steps=10, period=0 -> one step per clock; position passes 7->0; final position=2.
REQ-036 SHALL cover abort: steps=5, period=4, abort pulsed at E0+6 -> single step at E0+4; DONE after E0+6; position=1; steps_left=4.
REQ-037 SHALL cover zero steps and commands while busy: steps=0 -> done pulse at E0+1 with position unchanged; cmd_valid held during RUN -> ignored, cmd_ready=0; reset=0 mid-RUN -> values per REQ-030 at next edge.
